// File: rtl/spi_slave_pkg.sv
// Shared constants and helpers for the SPI scan slave: SCK mode encodings and
// the ceiling divide that sizes the transmitted word count.
package spi_slave_pkg;

  localparam int CPOL_LOW   = 0;
  localparam int CPOL_HIGH  = 1;
  localparam int CPHA_LEAD  = 0;
  localparam int CPHA_TRAIL = 1;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus a history flop; edges come from the last two stages.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign lvl_o  = sync_q;
  assign rise_o = sync_q & ~hist_q;
  assign fall_o = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_scan.sv
// SPI slave that reports a frame counter followed by a snapshot of din, and
// collects MOSI words; SPI pins are oversampled in the clk domain.
module spi_slave_scan
  import spi_slave_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 12,
  parameter int CPOL  = 0,
  parameter int CPHA  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             ssel_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [NIN-1:0]   din,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_first,
  output logic             frame_active,
  output logic             frame_done,
  output logic [WIDTH-1:0] frame_cnt
);

  localparam int K   = ceil_div(NIN, WIDTH);
  localparam int SHW = K * WIDTH;
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int IXW = $clog2(K + 2);
  localparam logic [IXW-1:0] IDX_MAX = IXW'(K + 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(WIDTH);
  localparam bit LEAD_IS_RISE   = (CPOL == CPOL_LOW);
  localparam bit SAMPLE_ON_LEAD = (CPHA == CPHA_LEAD);

  logic sck_rise, sck_fall, unused_sck_lvl;
  logic ssel_lvl, ssel_rise, ssel_fall;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.RST_VAL(CPOL != 0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d_i(sck),
    .lvl_o(unused_sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ssel (
    .clk(clk), .rst_n(rst_n), .d_i(ssel_n),
    .lvl_o(ssel_lvl), .rise_o(ssel_rise), .fall_o(ssel_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(mosi),
    .lvl_o(mosi_lvl), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  logic             active_q, active_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [IXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_first_q, rx_first_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             inc_q, inc_d;
  logic [SHW-1:0]   shadow_q, shadow_d;
  logic             armed_q, armed_d;
  logic [1:0]       settle_q, settle_d;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic frame_start, frame_end, settle_done;
  logic [WIDTH-1:0] rx_word;
  logic [BCW-1:0]   bc_inc;

  // Word 0 is the frame count, then the shadow MS chunk first, then zeros.
  function automatic logic [WIDTH-1:0] tx_word(input logic [IXW-1:0] idx,
                                               input logic [WIDTH-1:0] cnt,
                                               input logic [SHW-1:0] sh);
    logic [WIDTH-1:0] w;
    w = '0;
    if (idx == '0) w = cnt;
    else if (int'(idx) <= K) w = sh[(K - int'(idx)) * WIDTH +: WIDTH];
    return w;
  endfunction

  assign lead_edge   = LEAD_IS_RISE ? sck_rise : sck_fall;
  assign trail_edge  = LEAD_IS_RISE ? sck_fall : sck_rise;
  assign sample_edge = SAMPLE_ON_LEAD ? lead_edge : trail_edge;
  assign shift_edge  = SAMPLE_ON_LEAD ? trail_edge : lead_edge;

  // A select that was already low across reset must be seen high before it can open a frame.
  assign settle_done = (settle_q == 2'd3);
  assign frame_start = armed_q & ssel_fall;
  assign frame_end   = active_q & ssel_rise;

  assign rx_word = {rx_sh_q[WIDTH-2:0], mosi_lvl};
  assign bc_inc  = bitcnt_q + 1'b1;

  always_comb begin
    active_d   = active_q;
    bitcnt_d   = bitcnt_q;
    idx_d      = idx_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_first_d = rx_first_q;
    done_d     = 1'b0;
    shadow_d   = shadow_q;
    inc_d      = 1'b0;
    cnt_d      = inc_q ? cnt_q + 1'b1 : cnt_q;
    settle_d   = settle_done ? settle_q : settle_q + 2'd1;
    armed_d    = armed_q | (settle_done & ssel_lvl);

    if (frame_start) begin
      shadow_d = SHW'(din);
      tx_d     = cnt_q;
      bitcnt_d = '0;
      idx_d    = '0;
      active_d = 1'b1;
      inc_d    = 1'b1;
    end else if (frame_end) begin
      done_d   = 1'b1;
      active_d = 1'b0;
      bitcnt_d = '0;
      idx_d    = '0;
    end else if (active_q) begin
      if (sample_edge) begin
        rx_sh_d = rx_word;
        if (bc_inc == BC_FULL) begin
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
          rx_first_d = (idx_q == '0);
          bitcnt_d   = '0;
          if (idx_q != IDX_MAX) idx_d = idx_q + 1'b1;
        end else begin
          bitcnt_d = bc_inc;
        end
      end else if (shift_edge) begin
        if (bitcnt_q != '0) tx_d = {tx_q[WIDTH-2:0], 1'b0};
        else if (idx_q != '0) tx_d = tx_word(idx_q, cnt_q, shadow_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      bitcnt_q   <= '0;
      idx_q      <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      inc_q      <= 1'b0;
      shadow_q   <= '0;
      armed_q    <= 1'b0;
      settle_q   <= '0;
    end else begin
      active_q   <= active_d;
      bitcnt_q   <= bitcnt_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      inc_q      <= inc_d;
      shadow_q   <= shadow_d;
      armed_q    <= armed_d;
      settle_q   <= settle_d;
    end
  end

  assign miso         = active_q & tx_q[WIDTH-1];
  assign miso_oe      = active_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_first     = rx_first_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;
  assign frame_cnt    = cnt_q;

endmodule
